// File: rtl/rsa_core_host.sv
// Host-side sequencer for an RSA core: loads M/E/N over a strobed word bus,
// waits for the core's completion (or a timeout), and returns the result.
module rsa_core_host #(
    parameter int   DATA_WIDTH = 8,
    parameter logic LOAD       = 1'b0,
    parameter int   TIMEOUT    = 64
) (
    input  logic                  host_clk,
    input  logic                  host_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_m,
    input  logic [DATA_WIDTH-1:0] req_e,
    input  logic [DATA_WIDTH-1:0] req_n,
    output logic                  host_load,
    output logic [DATA_WIDTH-1:0] host_dout,
    input  logic                  host_done,
    input  logic                  host_err,
    input  logic [DATA_WIDTH-1:0] host_c,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_c,
    output logic                  rsp_err,
    output logic                  rsp_timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        START_UP, IDLE, DRV_M, GAP_M, DRV_E, GAP_E, DRV_N, WAIT_DONE, RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_half;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_m, r_e, r_n, r_dout;
    logic [DATA_WIDTH-1:0] r_rsp_c;
    logic                  r_rsp_err, r_rsp_timeout;
    logic                  w_accept, w_expired, w_drv;

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_expired = (r_cnt == CNT_LAST);
    assign w_drv     = (r_state == DRV_M) || (r_state == DRV_E) || (r_state == DRV_N);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            START_UP:  if (r_half)                  w_state_next = IDLE;
            IDLE:      if (req_valid)               w_state_next = DRV_M;
            DRV_M:     if (r_half)                  w_state_next = GAP_M;
            GAP_M:     if (r_half)                  w_state_next = DRV_E;
            DRV_E:     if (r_half)                  w_state_next = GAP_E;
            GAP_E:     if (r_half)                  w_state_next = DRV_N;
            DRV_N:     if (r_half)                  w_state_next = WAIT_DONE;
            WAIT_DONE: if (host_done || w_expired)  w_state_next = RESP;
            RESP:      if (rsp_ready)               w_state_next = IDLE;
            default:                                w_state_next = START_UP;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge host_clk or posedge host_rst) begin
        if (host_rst) begin
            r_state <= START_UP;
            r_half  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            // r_half marks the second cycle of the two-cycle states
            r_half  <= (w_state_next == r_state) ? ~r_half : 1'b0;
            r_cnt   <= (r_state == WAIT_DONE && w_state_next == WAIT_DONE) ? r_cnt + CW'(1) : '0;
        end
    end

    always_ff @(posedge host_clk or posedge host_rst) begin
        if (host_rst) begin
            r_m           <= '0;
            r_e           <= '0;
            r_n           <= '0;
            r_dout        <= '0;
            r_rsp_c       <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m    <= req_m;
                r_e    <= req_e;
                r_n    <= req_n;
                r_dout <= req_m;
            end
            // host_dout switches only when the next DRV state begins
            if (r_state == GAP_M && r_half) r_dout <= r_e;
            if (r_state == GAP_E && r_half) r_dout <= r_n;
            if (r_state == WAIT_DONE) begin
                if (host_done) begin
                    r_rsp_c       <= host_c;
                    r_rsp_err     <= host_err;
                    r_rsp_timeout <= 1'b0;
                end else if (w_expired) begin
                    r_rsp_c       <= '1;
                    r_rsp_err     <= 1'b0;
                    r_rsp_timeout <= 1'b1;
                end
            end
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign host_load   = w_drv ? LOAD : ~LOAD;
    assign host_dout   = r_dout;
    assign rsp_c       = r_rsp_c;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_rsa_core_host.sv
// Directed self-checking bench for rsa_core_host with default parameters
// (DATA_WIDTH=8, LOAD=0 so the strobe is active low, TIMEOUT=64).
module tb_rsa_core_host;

    localparam int   DW      = 8;
    localparam logic LOAD    = 1'b0;
    localparam int   TIMEOUT = 64;

    logic          host_clk = 1'b0;
    logic          host_rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_m = '0, req_e = '0, req_n = '0;
    logic          host_load;
    logic [DW-1:0] host_dout;
    logic          host_done = 1'b0;
    logic          host_err = 1'b0;
    logic [DW-1:0] host_c = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_c;
    logic          rsp_err;
    logic          rsp_timeout;

    int checks = 0;
    int errors = 0;

    rsa_core_host #(.DATA_WIDTH(DW), .LOAD(LOAD), .TIMEOUT(TIMEOUT)) dut (
        .host_clk   (host_clk),
        .host_rst   (host_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_m      (req_m),
        .req_e      (req_e),
        .req_n      (req_n),
        .host_load  (host_load),
        .host_dout  (host_dout),
        .host_done  (host_done),
        .host_err   (host_err),
        .host_c     (host_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_c      (rsp_c),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    always #5 host_clk = ~host_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Wait (bounded) for IDLE, present a request and let it be accepted at edge k.
    // Returns at the falling edge inside cycle k+1.
    task automatic do_accept(input logic [DW-1:0] m, input logic [DW-1:0] e, input logic [DW-1:0] n);
        int w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge host_clk);
            w++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: req_ready=%b expected 1 within 20 cycles", req_ready);
        end
        req_m = m; req_e = e; req_n = n;
        req_valid = 1'b1;
        @(posedge host_clk);
        @(negedge host_clk);
        req_valid = 1'b0;
    endtask

    // From cycle k+1 check the load windows and words; returns at cycle k+11 (WAIT_DONE entry).
    task automatic check_load_seq(input logic [DW-1:0] m, input logic [DW-1:0] e, input logic [DW-1:0] n);
        logic          exp_load;
        logic [DW-1:0] exp_dout;
        for (int i = 1; i <= 10; i++) begin
            exp_load = (i == 1 || i == 2 || i == 5 || i == 6 || i == 9 || i == 10) ? LOAD : ~LOAD;
            exp_dout = (i <= 4) ? m : (i <= 8) ? e : n;
            checks++;
            if (host_load !== exp_load) begin
                errors++;
                $display("FAIL load_k+%0d: host_load=%b expected %b", i, host_load, exp_load);
            end
            checks++;
            if (host_dout !== exp_dout) begin
                errors++;
                $display("FAIL dout_k+%0d: host_dout=%h expected %h", i, host_dout, exp_dout);
            end
            @(negedge host_clk);
        end
        checks++;
        if (host_load !== ~LOAD || host_dout !== n || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_entry: load=%b dout=%h rsp_valid=%b req_ready=%b expected %b %h 0 0",
                     host_load, host_dout, rsp_valid, req_ready, ~LOAD, n);
        end
    endtask

    task automatic check_rsp(input string name, input logic [DW-1:0] c, input logic err, input logic tmo);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_c !== c || rsp_err !== err || rsp_timeout !== tmo) begin
            errors++;
            $display("FAIL %s: valid=%b c=%h err=%b timeout=%b expected 1 %h %b %b",
                     name, rsp_valid, rsp_c, rsp_err, rsp_timeout, c, err, tmo);
        end
    endtask

    task automatic finish_rsp(input string name);
        rsp_ready = 1'b1;
        @(posedge host_clk);
        @(negedge host_clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: rsp_valid=%b req_ready=%b expected 0 1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge host_clk);
        checks++;
        if (host_load !== ~LOAD || host_dout !== 8'h00 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
            rsp_c !== 8'h00 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: load=%b dout=%h rdy=%b vld=%b c=%h err=%b tmo=%b expected %b 00 0 0 00 0 0",
                     host_load, host_dout, req_ready, rsp_valid, rsp_c, rsp_err, rsp_timeout, ~LOAD);
        end
        host_rst = 1'b0;
        @(negedge host_clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL startup_1: req_ready=%b expected 0", req_ready);
        end
        @(negedge host_clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL startup_2: req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_normal();
        do_accept(8'd5, 8'd3, 8'd33);
        check_load_seq(8'd5, 8'd3, 8'd33);
        repeat (2) @(negedge host_clk);
        host_done = 1'b1; host_c = 8'd26; host_err = 1'b0;
        @(negedge host_clk);
        host_done = 1'b0;
        check_rsp("normal_rsp", 8'd26, 1'b0, 1'b0);
        finish_rsp("normal");
    endtask

    task automatic test_error();
        do_accept(8'd7, 8'd0, 8'd0);
        check_load_seq(8'd7, 8'd0, 8'd0);
        host_done = 1'b1; host_c = 8'hFF; host_err = 1'b1;
        @(negedge host_clk);
        host_done = 1'b0; host_err = 1'b0;
        check_rsp("error_rsp", 8'hFF, 1'b1, 1'b0);
        finish_rsp("error");
    endtask

    task automatic test_timeout();
        logic early = 1'b0;
        do_accept(8'h0A, 8'h0B, 8'h0C);
        check_load_seq(8'h0A, 8'h0B, 8'h0C);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            @(negedge host_clk);
            if (rsp_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL timeout_early: rsp_valid=1 seen before cycle 64 expected 0");
        end
        @(negedge host_clk);
        check_rsp("timeout_rsp", 8'hFF, 1'b0, 1'b1);
        finish_rsp("timeout");
    endtask

    task automatic test_backpressure();
        do_accept(8'd9, 8'd4, 8'd17);
        check_load_seq(8'd9, 8'd4, 8'd17);
        host_done = 1'b1; host_c = 8'h2A; host_err = 1'b0;
        @(negedge host_clk);
        host_done = 1'b0;
        req_m = 8'd1; req_e = 8'd2; req_n = 8'd3;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_rsp($sformatf("bp_payload_%0d", i), 8'h2A, 1'b0, 1'b0);
            checks++;
            if (req_ready !== 1'b0 || host_dout !== 8'd17) begin
                errors++;
                $display("FAIL bp_ready_%0d: req_ready=%b dout=%h expected 0 11", i, req_ready, host_dout);
            end
            @(negedge host_clk);
        end
        rsp_ready = 1'b1;
        @(posedge host_clk);
        @(negedge host_clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || host_dout !== 8'd17 || host_load !== ~LOAD) begin
            errors++;
            $display("FAIL bp_idle: req_ready=%b rsp_valid=%b dout=%h load=%b expected 1 0 11 %b",
                     req_ready, rsp_valid, host_dout, host_load, ~LOAD);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_done_in_gap();
        logic early = 1'b0;
        do_accept(8'h21, 8'h22, 8'h23);
        repeat (6) @(negedge host_clk);
        host_done = 1'b1; host_c = 8'h55; host_err = 1'b1;
        @(negedge host_clk);
        host_done = 1'b0; host_err = 1'b0;
        for (int i = 0; i < 66; i++) begin
            @(negedge host_clk);
            if (rsp_valid !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL gap_done_early: rsp_valid=1 before timeout expected 0");
        end
        @(negedge host_clk);
        check_rsp("gap_done_timeout", 8'hFF, 1'b0, 1'b1);
        finish_rsp("gap_done");
    endtask

    task automatic test_reset_mid();
        logic seen_valid = 1'b0;
        do_accept(8'h11, 8'h22, 8'h33);
        repeat (4) @(negedge host_clk);
        checks++;
        if (host_load !== LOAD || host_dout !== 8'h22) begin
            errors++;
            $display("FAIL mid_drv_e: load=%b dout=%h expected %b 22", host_load, host_dout, LOAD);
        end
        host_rst = 1'b1;
        #1;
        checks++;
        if (host_load !== ~LOAD || host_dout !== 8'h00 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: load=%b dout=%h rdy=%b vld=%b expected %b 00 0 0",
                     host_load, host_dout, req_ready, rsp_valid, ~LOAD);
        end
        @(negedge host_clk);
        host_rst = 1'b0;
        @(negedge host_clk);
        if (rsp_valid !== 1'b0) seen_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_startup_1: req_ready=%b expected 0", req_ready);
        end
        @(negedge host_clk);
        if (rsp_valid !== 1'b0) seen_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1 || seen_valid) begin
            errors++;
            $display("FAIL mid_startup_2: req_ready=%b rsp_valid_seen=%b expected 1 0", req_ready, seen_valid);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_error();
        test_timeout();
        test_backpressure();
        test_done_in_gap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_core_host.md
RSA_CORE_HOST -- requirements
Module: rsa_core_host

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of operand and result words.
REQ-002 SHALL have parameter LOAD, default 1'b0, the active level of host_load.
REQ-003 SHALL have parameter TIMEOUT, default 64, the maximum cycles spent in WAIT_DONE.
REQ-004 SHALL have port host_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port host_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present; req_ready  output  1  request accepted when both are high at a clock edge.
REQ-007 SHALL have ports req_m, req_e, req_n  input  DATA_WIDTH  message, exponent and modulus.
REQ-008 SHALL have port host_load  output  1  load strobe to the core, active at level LOAD.
REQ-009 SHALL have port host_dout  output  DATA_WIDTH  word presented to the core.
REQ-010 SHALL have ports host_done  input  1, host_err  input  1, host_c  input  DATA_WIDTH  core completion pulse, error flag and result.
REQ-011 SHALL have ports rsp_valid  output  1 and rsp_ready  input  1  response handshake.
REQ-012 SHALL have ports rsp_c  output  DATA_WIDTH, rsp_err  output  1, rsp_timeout  output  1  response payload.

Function
REQ-013 SHALL implement the states START_UP, IDLE, DRV_M, GAP_M, DRV_E, GAP_E, DRV_N, WAIT_DONE and RESP.
REQ-014 START_UP SHALL last 2 cycles after reset release and then go to IDLE, so that the core reaches its M-load state first.
REQ-015 req_ready SHALL be high only in IDLE; on acceptance, req_m/req_e/req_n SHALL be latched and the state SHALL become DRV_M.
REQ-016 Each DRV_x state SHALL last exactly 2 cycles, drive host_load=LOAD and hold host_dout equal to the latched word for both cycles.
REQ-017 Each GAP_x state SHALL last exactly 2 cycles, drive host_load=~LOAD and hold host_dout at the last driven word.
REQ-018 The sequence SHALL be DRV_M -> GAP_M -> DRV_E -> GAP_E -> DRV_N -> WAIT_DONE; host_load SHALL be ~LOAD from WAIT_DONE onward.
REQ-019 Timing: acceptance at edge k gives host_load active in cycles k+1..k+2 (M), k+5..k+6 (E) and k+9..k+10 (N), with WAIT_DONE from k+11.
REQ-020 In WAIT_DONE, a cycle counter SHALL start at 0; host_done high at an edge SHALL capture rsp_c=host_c, rsp_err=host_err and rsp_timeout=0, then enter RESP.
REQ-021 If the counter reaches TIMEOUT-1 without host_done, the block SHALL enter RESP with rsp_c all ones, rsp_err=0 and rsp_timeout=1.
REQ-022 If host_done and timeout expiry coincide, host_done SHALL win.
REQ-023 host_done outside WAIT_DONE SHALL be ignored.
REQ-024 rsp_valid SHALL be high exactly in RESP; the payload SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-025 rsp_valid and rsp_ready both high at an edge SHALL return the block to IDLE; req_ready SHALL go high the next cycle (no same-cycle re-accept).
REQ-026 req_valid SHALL be ignored outside IDLE; latched operands SHALL not change until the next acceptance.
REQ-027 Operands are passed through unmodified; a zero modulus or exponent is forwarded, and the error is reported only via host_err.

Reset
REQ-028 On host_rst high the block SHALL asynchronously enter START_UP with the counter cleared.
REQ-029 During reset: host_load=~LOAD, host_dout=0, req_ready=0, rsp_valid=0, rsp_c=0, rsp_err=0, rsp_timeout=0, and all operand latches=0.
REQ-030 Reset mid-transaction SHALL abort it with no response issued; the sequence SHALL restart from START_UP.

Verification
REQ-031 Normal: m=5, e=3, n=33, core model pulses done with c=26 -> host_load windows per REQ-019, host_dout 5/3/33, then rsp_valid with rsp_c=26, err=0, timeout=0.
REQ-032 Error: n=0, core model returns done, err=1, c=8'hFF -> rsp_err=1, rsp_c=8'hFF, rsp_timeout=0.
REQ-033 Timeout: done never asserted, TIMEOUT=64 -> rsp_valid at 64 cycles after WAIT_DONE entry, rsp_c=8'hFF, rsp_timeout=1.
REQ-034 Backpressure: rsp_ready held low 10 cycles with req_valid high -> payload stable, req_ready=0 throughout, IDLE one cycle after rsp_ready rises.
REQ-035 Reset injected during DRV_E -> host_load=~LOAD immediately, no rsp_valid, req_ready high 2 cycles after reset release.
REQ-036 host_done pulse while in GAP_E, then no done -> pulse ignored, and the transaction completes by timeout per REQ-021.
